// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous SRAM between an instruction-fetch and a
// load/store requester: round-robin arbitration with single-cycle read return.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            inst_req,
    input  logic [AW-1:0]   inst_addr,
    input  logic            inst_flush,
    output logic            inst_ack,
    output logic            inst_rvalid,
    output logic [DW-1:0]   inst_rdata,
    input  logic            data_req,
    input  logic [DW/8-1:0] data_wen,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic            data_ack,
    output logic            data_rvalid,
    output logic [DW-1:0]   data_rdata,
    output logic            sram_en,
    output logic [DW/8-1:0] sram_wen,
    output logic [AW-1:0]   sram_addr,
    output logic [DW-1:0]   sram_wdata,
    input  logic [DW-1:0]   sram_rdata
);

    typedef enum logic {WIN_INST, WIN_DATA} winner_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

    winner_t       last_winner, last_winner_next;
    owner_t        owner, owner_next;
    logic          grant_inst, grant_data;
    logic [DW-1:0] inst_cap, data_cap;

    // Grants are gated by resetn so every output is quiet while reset is held.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (resetn) begin
            if (inst_req && data_req) begin
                if (last_winner == WIN_INST) grant_data = 1'b1;
                else                         grant_inst = 1'b1;
            end else begin
                grant_inst = inst_req;
                grant_data = data_req;
            end
        end
    end

    always_comb begin
        sram_en          = 1'b0;
        sram_wen         = '0;
        sram_addr        = '0;
        sram_wdata       = '0;
        inst_ack         = grant_inst;
        data_ack         = grant_data;
        owner_next       = OWN_NONE;
        last_winner_next = last_winner;
        if (grant_data) begin
            sram_en    = 1'b1;
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
            if (data_wen == '0) owner_next = OWN_DATA;
        end else if (grant_inst) begin
            sram_en    = 1'b1;
            sram_addr  = inst_addr;
            owner_next = OWN_INST;
        end
        // Round-robin history moves only when both sides actually competed.
        if (resetn && inst_req && data_req)
            last_winner_next = grant_data ? WIN_DATA : WIN_INST;
    end

    always_comb begin
        inst_rvalid = (owner == OWN_INST) && !inst_flush;
        data_rvalid = (owner == OWN_DATA);
        inst_rdata  = inst_rvalid ? sram_rdata : inst_cap;
        data_rdata  = data_rvalid ? sram_rdata : data_cap;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_winner <= WIN_INST;
            owner       <= OWN_NONE;
            inst_cap    <= '0;
            data_cap    <= '0;
        end else begin
            last_winner <= last_winner_next;
            owner       <= owner_next;
            if (inst_rvalid) inst_cap <= sram_rdata;
            if (data_rvalid) data_cap <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle-latency SRAM.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_flush, inst_ack, inst_rvalid;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_ack, data_rvalid;
    logic [3:0]  data_wen;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    int tests = 0;
    int fails = 0;

    logic [31:0] wmem    [0:255];
    logic        written [0:255];

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
        .inst_ack(inst_ack), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_ack(data_ack), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] preload(input logic [7:0] idx);
        case (idx)
            8'd4:    return 32'h1234_5678;
            8'd8:    return 32'hCAFE_F00D;
            8'd12:   return 32'hA5A5_0001;
            default: return {24'hEE0000, idx};
        endcase
    endfunction

    initial begin
        sram_rdata = '0;
        for (int i = 0; i < 256; i++) written[i] = 1'b0;
    end

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wen[b]) wmem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
                written[sram_addr[9:2]] <= 1'b1;
            end else begin
                sram_rdata <= written[sram_addr[9:2]] ? wmem[sram_addr[9:2]] : preload(sram_addr[9:2]);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; inst_req = 1'b0; inst_flush = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;

        // Reset values with both requests present
        @(negedge clk);
        inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h30; data_addr = 32'h20;
        data_wdata = 32'h1111_2222;
        #1;
        check("rst_inst_ack", 32'(inst_ack), 32'd0);
        check("rst_data_ack", 32'(data_ack), 32'd0);
        check("rst_sram_en", 32'(sram_en), 32'd0);
        check("rst_sram_wen", 32'(sram_wen), 32'd0);
        check("rst_sram_addr", sram_addr, 32'd0);
        check("rst_sram_wdata", sram_wdata, 32'd0);
        check("rst_rvalids", 32'({inst_rvalid, data_rvalid}), 32'd0);
        check("rst_inst_rdata", inst_rdata, 32'd0);
        check("rst_data_rdata", data_rdata, 32'd0);

        // Contended from reset: data, inst, data, inst
        @(negedge clk); resetn = 1'b1; #1;
        check("rr1_data_ack", 32'(data_ack), 32'd1);
        check("rr1_inst_ack", 32'(inst_ack), 32'd0);
        check("rr1_sram_addr", sram_addr, 32'h20);
        check("rr1_sram_en", 32'(sram_en), 32'd1);
        @(negedge clk);
        check("rr2_inst_ack", 32'(inst_ack), 32'd1);
        check("rr2_data_ack", 32'(data_ack), 32'd0);
        check("rr2_sram_addr", sram_addr, 32'h30);
        check("rr2_sram_wdata", sram_wdata, 32'd0);
        check("rr2_data_rvalid", 32'(data_rvalid), 32'd1);
        check("rr2_data_rdata", data_rdata, 32'hCAFE_F00D);
        @(negedge clk);
        check("rr3_data_ack", 32'(data_ack), 32'd1);
        check("rr3_inst_ack", 32'(inst_ack), 32'd0);
        check("rr3_inst_rvalid", 32'(inst_rvalid), 32'd1);
        check("rr3_inst_rdata", inst_rdata, 32'hA5A5_0001);
        @(negedge clk);
        check("rr4_inst_ack", 32'(inst_ack), 32'd1);
        check("rr4_data_ack", 32'(data_ack), 32'd0);
        @(posedge clk); #1 inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk);
        check("idle_sram_en", 32'(sram_en), 32'd0);
        check("idle_acks", 32'({inst_ack, data_ack}), 32'd0);
        check("idle_inst_rvalid", 32'(inst_rvalid), 32'd1);
        check("idle_data_hold", data_rdata, 32'hCAFE_F00D);

        // Fetch only, held three cycles
        @(posedge clk); #1 inst_req = 1'b1; inst_addr = 32'h10; data_wdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("f_inst_ack", 32'(inst_ack), 32'd1);
            check("f_sram_addr", sram_addr, 32'h10);
            check("f_sram_wdata", sram_wdata, 32'd0);
            check("f_inst_rvalid", 32'(inst_rvalid), (i == 0) ? 32'd0 : 32'd1);
            check("f_inst_rdata", inst_rdata, (i == 0) ? 32'hA5A5_0001 : 32'h1234_5678);
        end
        @(posedge clk); #1 inst_req = 1'b0;
        @(negedge clk);
        check("f_last_rvalid", 32'(inst_rvalid), 32'd1);
        check("f_last_rdata", inst_rdata, 32'h1234_5678);
        @(negedge clk);
        check("f_after_rvalid", 32'(inst_rvalid), 32'd0);
        check("f_after_hold", inst_rdata, 32'h1234_5678);

        // Store then load to the same address
        @(posedge clk); #1 data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("st_ack", 32'(data_ack), 32'd1);
        check("st_sram_wen", 32'(sram_wen), 32'hF);
        check("st_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
        check("st_sram_addr", sram_addr, 32'h100);
        @(posedge clk); #1 data_wen = 4'h0;
        @(negedge clk);
        check("ld_ack", 32'(data_ack), 32'd1);
        check("ld_sram_wen", 32'(sram_wen), 32'd0);
        check("st_no_rvalid", 32'(data_rvalid), 32'd0);
        @(posedge clk); #1 data_req = 1'b0;
        @(negedge clk);
        check("ld_rvalid", 32'(data_rvalid), 32'd1);
        check("ld_rdata", data_rdata, 32'hDEAD_BEEF);

        // Uncontended grants must not move round-robin history: data wins
        @(posedge clk); #1 inst_req = 1'b1; inst_addr = 32'h10; data_req = 1'b1; data_addr = 32'h20;
        @(negedge clk);
        check("rr5_data_ack", 32'(data_ack), 32'd1);
        check("rr5_inst_ack", 32'(inst_ack), 32'd0);
        check("rr5_sram_addr", sram_addr, 32'h20);
        @(posedge clk); #1 data_req = 1'b0;
        @(negedge clk);
        check("rr6_inst_ack", 32'(inst_ack), 32'd1);
        check("rr6_data_rdata", data_rdata, 32'hCAFE_F00D);

        // Flush during grant and return cycles
        @(posedge clk); #1 inst_addr = 32'h30; inst_flush = 1'b1;
        @(negedge clk);
        check("fl_grant_ack", 32'(inst_ack), 32'd1);
        check("fl_grant_addr", sram_addr, 32'h30);
        check("fl_prev_rvalid", 32'(inst_rvalid), 32'd0);
        @(posedge clk); #1 inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h100;
        @(negedge clk);
        check("fl_rvalid", 32'(inst_rvalid), 32'd0);
        check("fl_rdata_hold", inst_rdata, 32'h1234_5678);
        check("fl_data_ack", 32'(data_ack), 32'd1);
        @(posedge clk); #1 data_req = 1'b0;
        @(negedge clk);
        check("fl_data_rvalid", 32'(data_rvalid), 32'd1);
        check("fl_data_rdata", data_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1 inst_req = 1'b1; inst_addr = 32'h30;
        @(negedge clk);
        check("flT_ack", 32'(inst_ack), 32'd1);
        @(posedge clk); #1 inst_req = 1'b0; inst_flush = 1'b0;
        @(negedge clk);
        check("flT_rvalid", 32'(inst_rvalid), 32'd1);
        check("flT_rdata", inst_rdata, 32'hA5A5_0001);

        // Reset between a load grant and its return cycle
        @(posedge clk); #1 data_req = 1'b1; data_addr = 32'h20;
        @(negedge clk);
        check("rl_ack", 32'(data_ack), 32'd1);
        resetn = 1'b0; inst_req = 1'b1; #1;
        check("rl_acks", 32'({inst_ack, data_ack}), 32'd0);
        check("rl_sram_en", 32'(sram_en), 32'd0);
        check("rl_sram_addr", sram_addr, 32'd0);
        check("rl_inst_rdata", inst_rdata, 32'd0);
        check("rl_data_rdata", data_rdata, 32'd0);
        @(posedge clk); #1;
        check("rl_data_rvalid", 32'(data_rvalid), 32'd0);
        inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk); resetn = 1'b1;
        @(negedge clk);
        check("rl_post_rvalids", 32'({inst_rvalid, data_rvalid}), 32'd0);
        check("rl_post_rdata", data_rdata, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits; fixed byte-enable width is DW/8.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous and active-low.
REQ-005 inst_req  in  1  instruction-fetch read request, held high until inst_ack.
REQ-006 inst_addr  in  AW  fetch address, stable while inst_req high.
REQ-007 inst_flush  in  1  cancels the in-flight fetch result (mispredict or jump).
REQ-008 inst_ack  out  1  fetch request accepted this cycle.
REQ-009 inst_rvalid  out  1  fetch data valid this cycle.
REQ-010 inst_rdata  out  DW  fetch data.
REQ-011 data_req  in  1  load/store request, held high until data_ack.
REQ-012 data_wen  in  DW/8  byte write enables; zero means load.
REQ-013 data_addr  in  AW  load/store address.
REQ-014 data_wdata  in  DW  store data.
REQ-015 data_ack  out  1  load/store accepted this cycle.
REQ-016 data_rvalid  out  1  load data valid this cycle.
REQ-017 data_rdata  out  DW  load data.
REQ-018 sram_en  out  1  shared single-port SRAM enable.
REQ-019 sram_wen  out  DW/8  SRAM byte write enables.
REQ-020 sram_addr  out  AW  SRAM address.
REQ-021 sram_wdata  out  DW  SRAM write data.
REQ-022 sram_rdata  in  DW  SRAM read data, valid one cycle after sram_en.

Function
REQ-023 The block SHALL share one synchronous SRAM port between fetch and data requesters, issuing at most one access per cycle.
REQ-024 Arbitration SHALL be combinational in cycle T: one requester only -> it wins; both -> round-robin: winner is the requester not granted at the last contended arbitration; after reset, data wins first.
REQ-025 The last_winner register SHALL update only on contended cycles.
REQ-026 In the grant cycle, sram_en=1 and sram_addr/sram_wen/sram_wdata SHALL equal the winner's inputs; fetch grants drive sram_wen=0 and sram_wdata=0.
REQ-027 The winner's ack SHALL be high for exactly that cycle; the loser's ack stays 0 and its request remains pending.
REQ-028 With no request: sram_en=0, sram_wen=0, both acks 0.
REQ-029 A read-owner register SHALL record NONE/INST/DATA for the access issued in cycle T; a store records NONE.
REQ-030 In cycle T+1 the recorded owner's rvalid SHALL be 1 and its rdata SHALL equal sram_rdata combinationally.
REQ-031 Read latency SHALL be exactly 1 cycle, and back-to-back grants every cycle SHALL be sustained at full throughput.
REQ-032 Outside rvalid cycles, each rdata output SHALL hold the last value delivered to that requester, via a per-requester capture register loaded on its rvalid cycle.
REQ-033 inst_flush high in cycle T+1 SHALL force inst_rvalid=0 and leave inst_rdata unchanged.
REQ-034 inst_flush high in the grant cycle T SHALL NOT affect that grant; the fetch result is suppressed only if inst_flush is also high at T+1.
REQ-035 inst_flush SHALL never affect the data path.
REQ-036 A store grant SHALL produce no data_rvalid.
REQ-037 A load and store to the same address in consecutive cycles SHALL complete in grant order.

Reset
REQ-038 While resetn=0: all acks, rvalids, sram_en and sram_wen SHALL be 0; sram_addr, sram_wdata and both rdata outputs 0; read-owner NONE; last_winner set so data wins the first contended arbitration.
REQ-039 Reset asserted with a read in flight SHALL discard it, producing no rvalid after release.
REQ-040 The first grant SHALL occur in the first rising edge cycle with resetn=1 and a request present.

Verification
REQ-041 Fetch only, inst_addr=0x0000_0010 held 3 cycles, sram_rdata=0x1234_5678 at T+1 -> inst_ack in 3 consecutive cycles; inst_rvalid in cycle T+1 with inst_rdata=0x1234_5678.
REQ-042 Both requesting continuously from reset for 4 cycles -> grants alternate data, inst, data, inst.
REQ-043 Store data_wen=4'hF, data_addr=0x100, data_wdata=0xDEAD_BEEF, then load 0x100 -> sram_wen=4'hF in cycle 1, load data_rvalid in cycle 3 with 0xDEAD_BEEF, and no rvalid for the store.
REQ-044 Fetch granted at T with inst_flush=1 at T+1 -> inst_rvalid=0 at T+1; inst_rdata keeps its previous value.
REQ-045 resetn pulled low between a load grant and its T+1 -> data_rvalid stays 0 and all outputs reach reset values asynchronously.
